fir_fifo_ctrl: RTL and testbench

Sequencing controller for the FIR + FIFO datapath. It accepts a frame of input samples from a producer over a valid/ready handshake and drives the FIR enable and sample bus. It aligns the FIFO write strobe to the FIR output latency, and drains the FIFO to a downstream consumer through a 2-entry output buffer. Credit-based flow control guarantees the FIFO never overflows, so the free-running FIR pipeline never has to be stalled.

---
 rtl/fir_fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_fir_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_fifo_ctrl.sv
// Frame sequencer for the FIR + FIFO datapath: credit-limited issue, latency-aligned FIFO writes, 2-entry output buffer.
// Define FIR_CTRL_CHK_EN to build the sticky overflow/underflow checker driving err.
package fir_pkg;
   localparam int BIT_PREC = 16;
   localparam int DWIDTH   = 32;
endpackage

module fir_fifo_ctrl #(
   parameter int BIT_PREC   = fir_pkg::BIT_PREC,
   parameter int DWIDTH     = fir_pkg::DWIDTH,
   parameter int FIR_LAT    = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CNT_W-1:0]    frame_len,
   input  logic                s_valid,
   input  logic [BIT_PREC-1:0] s_data,
   output logic                s_ready,
   output logic                fir_en,
   output logic [BIT_PREC-1:0] in_wave,
   output logic                write_en,
   input  logic                full_flg,
   input  logic                empty_flg,
   output logic                read_en,
   input  logic [DWIDTH-1:0]   rdata,
   output logic                m_valid,
   output logic [DWIDTH-1:0]   m_data,
   input  logic                m_ready,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int CRW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   issued;
   logic [CRW-1:0]     credit;
   logic [FIR_LAT-1:0] pipe;
   logic               rd_pend;
   logic [1:0]         buf_cnt;
   logic [DWIDTH-1:0]  buf0, buf1;
   logic               start_acc;
   logic               pop;
   logic [2:0]         occ;

   assign start_acc = start && (state == IDLE);
   assign pop       = m_valid && m_ready;
   assign s_ready   = (state == RUN) && (credit != '0) && (issued < len_q);
   assign fir_en    = s_valid && s_ready;
   assign in_wave   = s_ready ? s_data : '0;
   assign write_en  = pipe[FIR_LAT-1];
   // Occupancy the buffer will have once the outstanding read lands, net of this cycle's pop.
   assign occ       = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign read_en   = rst_n && !empty_flg && (occ < 3'd2);
   assign m_valid   = (buf_cnt != 2'd0);
   assign m_data    = buf0;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (frame_len == '0) ? DONE : RUN;
         RUN:     if (issued == len_q) state_nxt = FLUSH;
         FLUSH:   if (pipe == '0) state_nxt = DRAIN;
         DRAIN:   if (empty_flg && !rd_pend && (buf_cnt == 2'd0)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q  <= '0;
         issued <= '0;
      end else if (start_acc) begin
         len_q  <= frame_len;
         issued <= '0;
      end else if (fir_en) begin
         issued <= issued + 1'b1;
      end
   end

   // Credits cover every result between issue and consumer hand-off, so the FIFO cannot overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                credit <= CRW'(FIFO_DEPTH);
      else if (start_acc)        credit <= CRW'(FIFO_DEPTH);
      else if (fir_en && !pop)   credit <= credit - 1'b1;
      else if (!fir_en && pop)   credit <= credit + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe <= '0;
      end else begin
         pipe[0] <= fir_en;
         for (int i = 1; i < FIR_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         buf_cnt <= 2'd0;
         buf0    <= '0;
         buf1    <= '0;
      end else begin
         rd_pend <= read_en;
         buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
         case ({rd_pend, pop})
            2'b01: buf0 <= buf1;
            2'b10: begin
               if (buf_cnt == 2'd0) buf0 <= rdata;
               else                 buf1 <= rdata;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf0 <= rdata;
               end else begin
                  buf0 <= buf1;
                  buf1 <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FIR_CTRL_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                             err <= 1'b0;
      else if (start_acc)                                     err <= 1'b0;
      else if ((write_en && full_flg) || (read_en && empty_flg)) err <= 1'b1;
   end
`else
   logic chk_unused;
   assign chk_unused = full_flg;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fir_fifo_ctrl.sv
// Self-checking bench for fir_fifo_ctrl: FIR/FIFO environment models plus an in-order result scoreboard.
module tb_fir_fifo_ctrl;
   localparam int BIT_PREC   = fir_pkg::BIT_PREC;
   localparam int DWIDTH     = fir_pkg::DWIDTH;
   localparam int FIR_LAT    = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [CNT_W-1:0]    frame_len;
   logic                s_valid;
   logic [BIT_PREC-1:0] s_data;
   logic                s_ready;
   logic                fir_en;
   logic [BIT_PREC-1:0] in_wave;
   logic                write_en;
   logic                full_flg;
   logic                empty_flg;
   logic                read_en;
   logic [DWIDTH-1:0]   rdata;
   logic                m_valid;
   logic [DWIDTH-1:0]   m_data;
   logic                m_ready;
   logic                busy;
   logic                done;
   logic                err;

   logic force_full;
   int   n_cmp = 0, n_fail = 0;
   int   n_acc, n_pop, n_done, n_busy, n_ovf;
   int   cyc = 0, first_acc, last_acc;
   logic [DWIDTH-1:0] exp_q[$];
   int   acc_q[$];

   always #5 clk = ~clk;

   fir_fifo_ctrl #(
      .BIT_PREC(BIT_PREC), .DWIDTH(DWIDTH), .FIR_LAT(FIR_LAT),
      .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .fir_en(fir_en), .in_wave(in_wave), .write_en(write_en),
      .full_flg(full_flg), .empty_flg(empty_flg), .read_en(read_en),
      .rdata(rdata), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .busy(busy), .done(done), .err(err)
   );

   function automatic logic [DWIDTH-1:0] fir_fn(input logic [BIT_PREC-1:0] x);
      return DWIDTH'(DWIDTH'(x) * 3 + 7);
   endfunction

   // Free-running FIR stand-in: result of the sample seen at edge N appears after edge N+FIR_LAT-1.
   logic [DWIDTH-1:0] fir_stage [FIR_LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIR_LAT; i++) fir_stage[i] <= '0;
      end else begin
         fir_stage[0] <= fir_fn(in_wave);
         for (int i = 1; i < FIR_LAT; i++) fir_stage[i] <= fir_stage[i-1];
      end
   end

   logic [DWIDTH-1:0] mem [FIFO_DEPTH];
   int fifo_cnt, wr_ptr, rd_ptr;
   always @(posedge clk or negedge rst_n) begin : fifo_model
      bit we_ok, re_ok;
      if (!rst_n) begin
         fifo_cnt <= 0; wr_ptr <= 0; rd_ptr <= 0; rdata <= '0;
      end else begin
         we_ok = write_en && (fifo_cnt < FIFO_DEPTH);
         re_ok = read_en && (fifo_cnt > 0);
         if (we_ok) begin
            mem[wr_ptr] <= fir_stage[FIR_LAT-1];
            wr_ptr <= (wr_ptr + 1) % FIFO_DEPTH;
         end
         if (re_ok) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= (rd_ptr + 1) % FIFO_DEPTH;
         end
         fifo_cnt <= fifo_cnt + int'(we_ok) - int'(re_ok);
      end
   end
   assign full_flg  = (fifo_cnt == FIFO_DEPTH) || force_full;
   assign empty_flg = (fifo_cnt == 0);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard sampled mid-cycle: accepted samples in, consumer beats out, write latency per sample.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (busy) n_busy++;
         if (done) n_done++;
         if (write_en && fifo_cnt == FIFO_DEPTH) n_ovf++;
         if (fir_en) begin
            check("in_wave", in_wave, s_data);
            check("credit_bound", (n_acc - n_pop) < FIFO_DEPTH, 1);
            exp_q.push_back(fir_fn(s_data));
            acc_q.push_back(cyc);
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
         end
         if (write_en) begin
            check("write_pending", acc_q.size() > 0, 1);
            if (acc_q.size() > 0) check("write_lat", cyc - acc_q.pop_front(), FIR_LAT);
         end
         if (m_valid && m_ready) begin
            check("beat_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
            n_pop++;
         end
      end
   end

   task automatic check_quiet(input string pfx);
      check({pfx, "_s_ready"},  s_ready,  0);
      check({pfx, "_fir_en"},   fir_en,   0);
      check({pfx, "_in_wave"},  in_wave,  0);
      check({pfx, "_write_en"}, write_en, 0);
      check({pfx, "_read_en"},  read_en,  0);
      check({pfx, "_m_valid"},  m_valid,  0);
      check({pfx, "_m_data"},   m_data,   0);
      check({pfx, "_busy"},     busy,     0);
      check({pfx, "_done"},     done,     0);
      check({pfx, "_err"},      err,      0);
   endtask

   task automatic run_frame(input int len, input int vpct, input int rpct, input int stall, input bit poke);
      int cycles;
      n_acc = 0; n_pop = 0; n_done = 0; n_busy = 0; n_ovf = 0;
      start = 1'b1; frame_len = CNT_W'(len);
      @(posedge clk); #1;
      start = 1'b0; frame_len = CNT_W'($urandom);
      cycles = 0;
      while (n_done == 0 && cycles < 4000) begin
         if (stall > 0 && cycles == stall) begin
            check("stall_accepts", n_acc, FIFO_DEPTH);
            check("stall_s_ready", s_ready, 0);
            check("stall_m_valid", m_valid, 1);
            check("stall_fifo_level", fifo_cnt, FIFO_DEPTH - 2);
         end
         s_valid = ($urandom_range(99) < vpct);
         s_data  = BIT_PREC'($urandom);
         m_ready = (cycles >= stall) && ($urandom_range(99) < rpct);
         start   = poke && (cycles == 3);
         if (start) frame_len = CNT_W'(3);
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      check("frame_done_once", n_done, 1);
      check("accepts", n_acc, len);
      check("beats", n_pop, len);
      check("results_left", exp_q.size(), 0);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      check("no_overflow", n_ovf, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic exp_err;
      int   guard;
`ifdef FIR_CTRL_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_n = 1'b0; start = 1'b1; frame_len = CNT_W'(5);
      s_valid = 1'b1; s_data = BIT_PREC'($urandom); m_ready = 1'b1; force_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_quiet("reset");
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("[TB] frame of 8, back-to-back, with an ignored start mid-frame");
      run_frame(8, 100, 100, 0, 1'b1);
      check("accept_span", last_acc - first_acc, 7);

      $display("[TB] empty frame");
      run_frame(0, 100, 100, 0, 1'b0);

      $display("[TB] frame of 40 with consumer stalled");
      run_frame(40, 100, 100, 30, 1'b0);
      check("err_clean", err, 0);

      $display("[TB] frame of 100, random valid/ready");
      run_frame(100, 60, 50, 0, 1'b0);

      $display("[TB] reset mid-frame");
      n_acc = 0; n_pop = 0;
      start = 1'b1; frame_len = CNT_W'(20); s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (n_acc < 5 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("abort_point", n_acc >= 5, 1);
      #2 rst_n = 1'b0;
      #1 check_quiet("rst_mid");
      repeat (2) @(posedge clk);
      exp_q.delete(); acc_q.delete();
      s_valid = 1'b0; m_ready = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(3, 100, 100, 0, 1'b0);

      $display("[TB] full flag forced during writes");
      force_full = 1'b1;
      run_frame(4, 100, 100, 0, 1'b0);
      force_full = 1'b0;
      check("err_set", err, exp_err);
      repeat (5) @(posedge clk);
      #1 check("err_sticky", err, exp_err);
      run_frame(2, 100, 100, 0, 1'b0);
      check("err_cleared", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
